hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

- Pipeline hazard controller: computes the operand forwarding selects consumed by the execute stage, and generates the stall/flush controls that drive the IF/ID and ID/EX pipeline registers.
- Handles load-use stalls and taken-branch flushes with a small flush-sequencing state machine.
- Optional saturating performance counters.
- Sits beside the five-stage pipeline and closes the backward control path from the E/M/W stages to the F/D/E segment registers.

## Interface
- FLUSH_CYCLES, default 2, number of consecutive cycles FlushD/FlushE stay high after a taken branch (legal 1..7).
- CNT_W, default 16, width of performance counters.

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset, sampled on rising edge of clk
- RA1D, RA2D  in  4  source register numbers of the instruction in decode
- RA1E, RA2E  in  4  source register numbers of the instruction in execute
- WA3E, WA3M, WA3W  in  4  destination register numbers in E, M, W
- RegWriteE, RegWriteM, RegWriteW  in  1  register-write enables per stage
- MemtoRegE  in  1  instruction in E is a load
- BranchTakenE  in  1  branch resolved taken in E this cycle
- ForwardAE, ForwardBE  out  2  operand select: 00 regfile, 01 result from W, 10 ALU result from M
- StallF, StallD  out  1  hold PC and IF/ID register
- FlushD, FlushE  out  1  clear IF/ID and ID/EX registers to bubble
- StallCnt, FlushCnt  out  CNT_W  performance counters (HAZARD_PERF_EN only)

## Operation
- Forwarding, combinational, per operand X in {A,B}:
  - 10 if RegWriteM and WA3M == RA{X}E and RA{X}E != 4'hF.
  - Otherwise 01 if RegWriteW and WA3W == RA{X}E and RA{X}E != 4'hF.
  - Otherwise 00.
  - M has priority over W. R15 (PC) is never forwarded.
- ldrstall = MemtoRegE & RegWriteE & (RA1D == WA3E | RA2D == WA3E).
- State machine, states RUN and FLUSH, with a 3-bit counter cnt.
- In RUN:
  - FlushD = BranchTakenE.
  - FlushE = BranchTakenE | ldrstall.
  - StallF = StallD = ldrstall & ~BranchTakenE. A branch flush takes precedence over a load stall, because the stalled consumer is squashed.
  - If BranchTakenE and FLUSH_CYCLES > 1: next state FLUSH, cnt <= FLUSH_CYCLES-1. Otherwise stay in RUN.
- In FLUSH:
  - FlushD = FlushE = 1. StallF = StallD = 0.
  - BranchTakenE and ldrstall are ignored, since the instructions involved are wrong-path.
  - cnt decrements each cycle. When cnt == 1, next state is RUN.
- Forwarding outputs are independent of state.

## Timing
- Forwarding, stall and flush outputs are combinational from the current inputs and the registered state; zero-cycle latency.
- A load-use stall lasts exactly one cycle per hazard, since the load advances to M and forwarding takes over. Back-to-back hazards produce consecutive one-cycle stalls.
- A taken branch produces flush pulses for exactly FLUSH_CYCLES cycles: the branch cycle plus FLUSH_CYCLES-1 cycles in FLUSH.
- Reset: state RUN, cnt 0, StallCnt 0, FlushCnt 0.
  - While rst is high, the state/counter-derived outputs still follow the RUN equations, because reset is synchronous.
  - Reset asserted mid-FLUSH: the next edge returns to RUN. No residual flush.
- Counters:
  - StallCnt increments on each cycle with StallD = 1.
  - FlushCnt increments on each cycle with FlushE = 1.
  - Both saturate at all-ones and never wrap.

## Configuration
- HAZARD_PERF_EN defined: StallCnt/FlushCnt ports and their registers are present and behave as specified.
- HAZARD_PERF_EN undefined: the counter ports and logic are removed. Hazard behaviour is identical.

## Structure
- Shared package hazard_pkg:
  - fwd_sel_t enum (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10).
  - hz_state_t enum (RUN, FLUSH).
  - Constant PC_REG = 4'hF.
- One sub-module, fwd_mux_sel: combinational per-operand forward select, instantiated twice (A, B).
- FSM, counter and performance counters live in hazard_ctrl.

## Test plan
- Forward priority: RA1E=3, WA3M=3, RegWriteM=1, WA3W=3, RegWriteW=1 -> ForwardAE=10. With RegWriteM=0 -> 01. With RA1E=15 -> 00.
- Load-use: MemtoRegE=1, RegWriteE=1, WA3E=5, RA2D=5 -> StallF=StallD=FlushE=1 for one cycle, FlushD=0. Next cycle with no hazard -> all 0.
- Branch flush: FLUSH_CYCLES=3, single-cycle BranchTakenE pulse -> FlushD=FlushE=1 for exactly 3 cycles, then 0. A second BranchTakenE during FLUSH does not extend it.
- Simultaneous: BranchTakenE=1 and ldrstall=1 in RUN -> FlushD=FlushE=1, StallF=StallD=0.
- Reset mid-flush: rst=1 on the second FLUSH cycle -> RUN on the next edge, FlushD=0 with BranchTakenE=0, counters 0.
- HAZARD_PERF_EN with CNT_W=4: 20 stall cycles -> StallCnt holds at 4'hF.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } hz_state_t;

    // R15 holds the PC and is never a forwarding target.
    localparam logic [3:0] PC_REG = 4'hF;

    function automatic logic fwd_hit(input logic       we,
                                     input logic [3:0] wa,
                                     input logic [3:0] ra);
        return we && (wa == ra) && (ra != PC_REG);
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_mux_sel.sv
// Per-operand forward select for the execute stage; M beats W.
module fwd_mux_sel
    import hazard_pkg::*;
(
    input  logic [3:0] ra_e,
    input  logic [3:0] wa_m,
    input  logic [3:0] wa_w,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    output fwd_sel_t   fwd_sel
);

    always_comb begin
        fwd_sel = FWD_RF;
        if (fwd_hit(reg_write_m, wa_m, ra_e)) begin
            fwd_sel = FWD_M;
        end else if (fwd_hit(reg_write_w, wa_w, ra_e)) begin
            fwd_sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: forwarding selects, load-use stall, branch flush sequencing.
// Define HAZARD_PERF_EN to add saturating StallCnt/FlushCnt performance counters.
//
// state | meaning
// RUN   | normal issue; load-use stalls and branch flushes decoded from inputs
// FLUSH | squashing wrong-path instructions after a taken branch; cnt counts down
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       RA1D,
    input  logic [3:0]       RA2D,
    input  logic [3:0]       RA1E,
    input  logic [3:0]       RA2E,
    input  logic [3:0]       WA3E,
    input  logic [3:0]       WA3M,
    input  logic [3:0]       WA3W,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             BranchTakenE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
`endif
);

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7 || CNT_W < 1) begin : g_param_check
        $error("hazard_ctrl: FLUSH_CYCLES must be 1..7 and CNT_W >= 1");
    end

    fwd_sel_t  fwd_a;
    fwd_sel_t  fwd_b;
    hz_state_t state_q;
    hz_state_t state_d;
    logic [2:0] cnt_q;
    logic [2:0] cnt_d;
    logic       ldrstall;
    logic       stall;

    fwd_mux_sel u_fwd_a (
        .ra_e        (RA1E),
        .wa_m        (WA3M),
        .wa_w        (WA3W),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd_sel     (fwd_a)
    );

    fwd_mux_sel u_fwd_b (
        .ra_e        (RA2E),
        .wa_m        (WA3M),
        .wa_w        (WA3W),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd_sel     (fwd_b)
    );

    assign ForwardAE = fwd_a;
    assign ForwardBE = fwd_b;

    assign ldrstall = MemtoRegE & RegWriteE & ((RA1D == WA3E) | (RA2D == WA3E));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        FlushD  = 1'b0;
        FlushE  = 1'b0;
        case (state_q)
            RUN: begin
                // A taken branch squashes the stalled consumer, so it wins.
                FlushD = BranchTakenE;
                FlushE = BranchTakenE | ldrstall;
                stall  = ldrstall & ~BranchTakenE;
                if (BranchTakenE && (FLUSH_CYCLES > 1)) begin
                    state_d = FLUSH;
                    cnt_d   = FLUSH_INIT;
                end
            end
            FLUSH: begin
                FlushD = 1'b1;
                FlushE = 1'b1;
                cnt_d  = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 3'd0;
            end
        endcase
    end

    assign StallF = stall;
    assign StallD = stall;

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            if (StallD && (StallCnt != '1)) begin
                StallCnt <= StallCnt + CNT_W'(1);
            end
            if (FlushE && (FlushCnt != '1)) begin
                FlushCnt <= FlushCnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (FLUSH_CYCLES=3, CNT_W=4).
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, BranchTakenE;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, FlushD, FlushE;
`ifdef HAZARD_PERF_EN
    logic [3:0] StallCnt, FlushCnt;
`endif

    int checks = 0;
    int errors = 0;

    // {ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE}
    logic [7:0] exp_q[$];
    logic [7:0] cnt_q[$];
    logic [7:0] obs;
    assign obs = {ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE};

    always #5 clk = ~clk;

    hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .RA1D         (RA1D),
        .RA2D         (RA2D),
        .RA1E         (RA1E),
        .RA2E         (RA2E),
        .WA3E         (WA3E),
        .WA3M         (WA3M),
        .WA3W         (WA3W),
        .RegWriteE    (RegWriteE),
        .RegWriteM    (RegWriteM),
        .RegWriteW    (RegWriteW),
        .MemtoRegE    (MemtoRegE),
        .BranchTakenE (BranchTakenE),
        .ForwardAE    (ForwardAE),
        .ForwardBE    (ForwardBE),
        .StallF       (StallF),
        .StallD       (StallD),
        .FlushD       (FlushD),
        .FlushE       (FlushE)
`ifdef HAZARD_PERF_EN
        ,
        .StallCnt     (StallCnt),
        .FlushCnt     (FlushCnt)
`endif
    );

    task automatic idle();
        RA1D = 4'd0; RA2D = 4'd0; RA1E = 4'd0; RA2E = 4'd0;
        WA3E = 4'd0; WA3M = 4'd0; WA3W = 4'd0;
        RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        MemtoRegE = 1'b0; BranchTakenE = 1'b0;
    endtask

    // Load in E writing r5, consumer in D reading r5 on operand 2.
    task automatic load_use();
        MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd5; RA2D = 4'd5; RA1D = 4'd1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        next_cycle();
        rst = 1'b1;
        idle();
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] e;
        // In reset with a branch asserted the outputs still follow RUN equations.
        next_cycle();
        rst = 1'b1; idle();
        exp_q.push_back(8'b0000_0000);
        @(negedge clk); e = exp_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL reset_idle got %b want %b", obs, e); end
        next_cycle();
        BranchTakenE = 1'b1;
        exp_q.push_back(8'b0000_0011);
        @(negedge clk); e = exp_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL reset_branch got %b want %b", obs, e); end
        next_cycle();
        BranchTakenE = 1'b0;
        exp_q.push_back(8'b0000_0000);
        @(negedge clk); e = exp_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL reset_no_residual got %b want %b", obs, e); end
        next_cycle();
        rst = 1'b0;
`ifdef HAZARD_PERF_EN
        @(negedge clk); checks++;
        if ({StallCnt, FlushCnt} !== 8'h00) begin
            errors++; $display("FAIL reset_counters got %h want 00", {StallCnt, FlushCnt});
        end
`endif
    endtask

    task automatic test_forward();
        // ra1e, ra2e, wa3m, wa3w, rwm, rww, expected {A,B}
        logic [3:0] ra1e_t[7] = '{4'd3, 4'd3, 4'd15, 4'd2, 4'd2, 4'd6, 4'd9};
        logic [3:0] ra2e_t[7] = '{4'd0, 4'd0, 4'd15, 4'd7, 4'd7, 4'd6, 4'd15};
        logic [3:0] wam_t[7]  = '{4'd3, 4'd3, 4'd15, 4'd7, 4'd7, 4'd6, 4'd9};
        logic [3:0] waw_t[7]  = '{4'd3, 4'd3, 4'd15, 4'd2, 4'd2, 4'd6, 4'd15};
        logic       rwm_t[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic       rww_t[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [3:0] exp_t[7]  = '{4'b1000, 4'b0100, 4'b0000, 4'b0110, 4'b0000, 4'b1010, 4'b1000};
        logic [7:0] e;
        for (int i = 0; i < 7; i++) begin
            next_cycle();
            idle();
            RA1E = ra1e_t[i]; RA2E = ra2e_t[i]; WA3M = wam_t[i]; WA3W = waw_t[i];
            RegWriteM = rwm_t[i]; RegWriteW = rww_t[i];
            exp_q.push_back({exp_t[i], 4'b0000});
            @(negedge clk); e = exp_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL forward step %0d got %b want %b", i, obs, e); end
        end
    endtask

    task automatic test_load_use();
        logic [7:0] e;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            idle();
            case (i)
                0: begin load_use(); exp_q.push_back(8'b0000_1101); end
                1: exp_q.push_back(8'b0000_0000);
                2: begin load_use(); RA2D = 4'd0; RA1D = 4'd5; exp_q.push_back(8'b0000_1101); end
                3: begin load_use(); RegWriteE = 1'b0; exp_q.push_back(8'b0000_0000); end
                default: begin load_use(); MemtoRegE = 1'b0; exp_q.push_back(8'b0000_0000); end
            endcase
            @(negedge clk); e = exp_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL load_use step %0d got %b want %b", i, obs, e); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            idle();
            if (i < 2) begin load_use(); exp_q.push_back(8'b0000_1101); end
            else exp_q.push_back(8'b0000_0000);
            @(negedge clk); e = exp_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL back_to_back step %0d got %b want %b", i, obs, e); end
        end
    endtask

    // Branch pulse at step 0; optional re-branch plus load-use in the first FLUSH cycle.
    task automatic test_branch_flush(input logic rebranch);
        logic [7:0] e;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            idle();
            if (i == 0) BranchTakenE = 1'b1;
            if (i == 1 && rebranch) begin BranchTakenE = 1'b1; load_use(); end
            exp_q.push_back(i < 3 ? 8'b0000_0011 : 8'b0000_0000);
            @(negedge clk); e = exp_q.pop_front(); checks++;
            if (obs !== e) begin
                errors++; $display("FAIL branch_flush rb=%0b step %0d got %b want %b", rebranch, i, obs, e);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] e;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            idle();
            if (i == 0) begin BranchTakenE = 1'b1; load_use(); end
            exp_q.push_back(i < 3 ? 8'b0000_0011 : 8'b0000_0000);
            @(negedge clk); e = exp_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL simultaneous step %0d got %b want %b", i, obs, e); end
        end
    endtask

    // Reset lands in the first FLUSH cycle, when two flush cycles would otherwise remain.
    task automatic test_reset_mid_flush();
        logic [7:0] e;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            idle();
            rst = (i == 1);
            if (i == 0) BranchTakenE = 1'b1;
            exp_q.push_back(i < 2 ? 8'b0000_0011 : 8'b0000_0000);
            @(negedge clk); e = exp_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL reset_mid_flush step %0d got %b want %b", i, obs, e); end
        end
`ifdef HAZARD_PERF_EN
        checks++;
        if ({StallCnt, FlushCnt} !== 8'h00) begin
            errors++; $display("FAIL reset_mid_flush_counters got %h want 00", {StallCnt, FlushCnt});
        end
`endif
    endtask

`ifdef HAZARD_PERF_EN
    task automatic test_counters();
        logic [7:0] e;
        do_reset();
        for (int i = 0; i < 3; i++) begin next_cycle(); idle(); load_use(); end
        next_cycle(); idle();
        cnt_q.push_back({4'd3, 4'd3});
        @(negedge clk); e = cnt_q.pop_front(); checks++;
        if ({StallCnt, FlushCnt} !== e) begin
            errors++; $display("FAIL counters_stall got %h want %h", {StallCnt, FlushCnt}, e);
        end
        BranchTakenE = 1'b1;
        next_cycle(); idle();
        next_cycle(); next_cycle(); next_cycle();
        cnt_q.push_back({4'd3, 4'd6});
        @(negedge clk); e = cnt_q.pop_front(); checks++;
        if ({StallCnt, FlushCnt} !== e) begin
            errors++; $display("FAIL counters_flush got %h want %h", {StallCnt, FlushCnt}, e);
        end
        for (int i = 0; i < 20; i++) begin next_cycle(); idle(); load_use(); end
        next_cycle(); idle();
        cnt_q.push_back(8'hFF);
        @(negedge clk); e = cnt_q.pop_front(); checks++;
        if ({StallCnt, FlushCnt} !== e) begin
            errors++; $display("FAIL counters_saturate got %h want %h", {StallCnt, FlushCnt}, e);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_forward();
        test_load_use();
        test_back_to_back();
        test_branch_flush(1'b0);
        test_branch_flush(1'b1);
        test_simultaneous();
        test_reset_mid_flush();
`ifdef HAZARD_PERF_EN
        test_counters();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
